// File: rtl/serial_ripple_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the bit-serial ripple-borrow subtractor:
//   - state_t   : controller states (IDLE, RUN, DONE)
//   - WIDTH_DEF : default operand width
//   - cntWidth  : width of the bit counter needed to count 0..width
// No ports (package).
// ---------------------------------------------------------------------------
package sub_pkg;

  // Controller states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand/result width.
  localparam int WIDTH_DEF = 4;

  // Bit-counter width: enough bits to hold the values 0..width.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_ripple_subtractor_cell.sv
// ---------------------------------------------------------------------------
// full_subtractor_cell
// Purely combinational one-bit full subtractor: computes a - b - bin.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// ---------------------------------------------------------------------------
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // A borrow leaves this bit when b exceeds a outright, or when the bits are
  // equal and a borrow is already coming in.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_ripple_subtractor.sv
// ---------------------------------------------------------------------------
// serial_ripple_subtractor
// Bit-serial ripple-borrow subtractor: out = x - y - borrowin, one bit per
// clock, LSB first, through a single full_subtractor_cell.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN (registers the signed
// overflow flag; when undefined the overflow port is tied to 0).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, ready    : request handshake (accepted when both are 1)
//   x, y, borrowin  : operands, sampled on the accept edge
//   valid, ack      : result handshake (result taken when both are 1)
//   out, borrowout  : difference and final borrow
//   overflow        : signed overflow flag
// ---------------------------------------------------------------------------
module serial_ripple_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = cntWidth(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrowin,
  output logic             ready,
  output logic             valid,
  input  logic             ack,
  output logic [WIDTH-1:0] out,
  output logic             borrowout,
  output logic             overflow
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   x_q, y_q, out_q;
  logic [CNT_W-1:0]   bitCnt_q;
  logic               borrow_q;
  logic               borrowOut_q;

  logic               accept;
  logic               lastBit;
  logic [WIDTH-1:0]   bitMask;
  logic               xBit, yBit;
  logic               diffBit, borrowNext;

  assign accept  = (state_q == IDLE) && start;
  assign lastBit = (bitCnt_q == CNT_W'(WIDTH - 1));

  // One-hot select of the bit being processed; avoids indexing with a counter
  // whose width differs from the operand index width.
  assign bitMask = WIDTH'(1) << bitCnt_q;
  assign xBit    = |(x_q & bitMask);
  assign yBit    = |(y_q & bitMask);

  full_subtractor_cell uCell (
    .a    (xBit),
    .b    (yBit),
    .bin  (borrow_q),
    .d    (diffBit),
    .bout (borrowNext)
  );

  // State register: reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start only counts in IDLE, ack only counts in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)   state_d = RUN;
      RUN:     if (lastBit) state_d = DONE;
      DONE:    if (ack)     state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    ready = (state_q == IDLE);
    valid = (state_q == DONE);
  end

  // Datapath: latch operands on accept, then fold one difference bit per RUN
  // cycle into the result. Result bits not yet written stay 0 because the
  // result register is cleared on accept and only ORed into.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      out_q       <= '0;
      bitCnt_q    <= '0;
      borrow_q    <= 1'b0;
      borrowOut_q <= 1'b0;
    end else if (accept) begin
      x_q         <= x;
      y_q         <= y;
      out_q       <= '0;
      bitCnt_q    <= '0;
      borrow_q    <= borrowin;
      borrowOut_q <= 1'b0;
    end else if (state_q == RUN) begin
      out_q    <= out_q | (bitMask & {WIDTH{diffBit}});
      borrow_q <= borrowNext;
      bitCnt_q <= bitCnt_q + CNT_W'(1);
      if (lastBit) borrowOut_q <= borrowNext;
    end
  end

  assign out       = out_q;
  assign borrowout = borrowOut_q;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic overflow_q;

  // Signed overflow: operand signs differ and the result sign differs from
  // the minuend. The result MSB is the difference bit produced on the last
  // RUN cycle, so it is taken straight from the cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (accept) begin
      overflow_q <= 1'b0;
    end else if ((state_q == RUN) && lastBit) begin
      overflow_q <= (x_q[WIDTH-1] != y_q[WIDTH-1]) && (diffBit != x_q[WIDTH-1]);
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_ripple_subtractor
// Self-checking bench for serial_ripple_subtractor (WIDTH=4). Expected values
// come from an arithmetic reference model of x - y - borrowin.
// ---------------------------------------------------------------------------
module tb_serial_ripple_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x, y;
  logic         borrowin;
  logic         ready, valid, ack;
  logic [W-1:0] out;
  logic         borrowout, overflow;

  int checks   = 0;
  int failures = 0;

  int expOut, expBorrow, expOvf;

  always #5 clk = ~clk;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x         (x),
    .y         (y),
    .borrowin  (borrowin),
    .ready     (ready),
    .valid     (valid),
    .ack       (ack),
    .out       (out),
    .borrowout (borrowout),
    .overflow  (overflow)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: plain integer arithmetic modulo 2^W, unsigned borrow,
  // and signed overflow judged by whether the true signed result fits.
  task automatic refModel(input int xv, input int yv, input int bv);
    int diff, sx, sy, sdiff;
    diff      = xv - yv - bv;
    expOut    = diff & ((1 << W) - 1);
    expBorrow = (xv < yv + bv) ? 1 : 0;
    sx        = (xv >= (1 << (W - 1))) ? xv - (1 << W) : xv;
    sy        = (yv >= (1 << (W - 1))) ? yv - (1 << W) : yv;
    sdiff     = sx - sy - bv;
`ifdef SERIAL_SUB_OVERFLOW_EN
    expOvf    = (sdiff < -(1 << (W - 1)) || sdiff > (1 << (W - 1)) - 1) ? 1 : 0;
`else
    expOvf    = 0;
`endif
  endtask

  // Wait (bounded) for valid, counting edges after the accept edge.
  task automatic waitValid(input string tag, input int expectedLatency);
    int waited;
    waited = 0;
    while (!valid && waited < 4 * W + 4) begin
      @(negedge clk);
      start = 1'b0;
      waited++;
    end
    checkOutput({tag, "_latency"}, waited, expectedLatency);
  endtask

  // Issue one request from IDLE and run it to DONE, checking latency and the
  // result. When disturb is set, start is re-pulsed with other operands
  // during RUN, which must be ignored.
  task automatic applyStimulus(input string tag, input int xv, input int yv,
                               input int bv, input bit disturb);
    @(negedge clk);
    checkOutput({tag, "_readyIdle"}, ready, 1);
    start = 1'b1; x = W'(xv); y = W'(yv); borrowin = bv[0];
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_readyDrop"}, ready, 0);
    if (disturb) begin
      start = 1'b1; x = W'(1); y = W'(1); borrowin = 1'b0;
    end
    waitValid(tag, W);
    refModel(xv, yv, bv);
    checkOutput({tag, "_out"}, out, expOut);
    checkOutput({tag, "_borrow"}, borrowout, expBorrow);
    checkOutput({tag, "_ovf"}, overflow, expOvf);
  endtask

  // Acknowledge the held result and confirm the return to IDLE with the
  // result still visible.
  task automatic ackResult(input string tag);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput({tag, "_validLow"}, valid, 0);
    checkOutput({tag, "_readyHigh"}, ready, 1);
    checkOutput({tag, "_outHeld"}, out, expOut);
    checkOutput({tag, "_borrowHeld"}, borrowout, expBorrow);
  endtask

  initial begin
    bit sawValid;
    int rx, ry, rb;

    rst_n = 1'b0; start = 1'b0; ack = 1'b0;
    x = '0; y = '0; borrowin = 1'b0;
    #12;
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_out", out, 0);
    checkOutput("rst_borrow", borrowout, 0);
    checkOutput("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the test plan.
    applyStimulus("sub9m3", 9, 3, 0, 1'b0);
    ackResult("sub9m3");
    applyStimulus("sub3m9", 3, 9, 0, 1'b0);
    ackResult("sub3m9");
    applyStimulus("sub0m0b", 0, 0, 1, 1'b0);
    ackResult("sub0m0b");
    applyStimulus("sub7m8", 7, 8, 0, 1'b0);
    ackResult("sub7m8");

    // start re-pulsed during RUN is ignored; then ack held low for 10 cycles.
    applyStimulus("ignStart", 9, 3, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", valid, 1);
      checkOutput("hold_out", out, 6);
      checkOutput("hold_borrow", borrowout, 0);
    end
    ackResult("ignStart");

    // start and ack together in DONE: ack wins, start is taken a cycle later.
    applyStimulus("startAck", 5, 2, 0, 1'b0);
    @(negedge clk);
    start = 1'b1; ack = 1'b1; x = W'(12); y = W'(5); borrowin = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("startAck_ready", ready, 1);
    checkOutput("startAck_valid", valid, 0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("startAck_accept", ready, 0);
    waitValid("startAck2", W);
    refModel(12, 5, 1);
    checkOutput("startAck2_out", out, expOut);
    checkOutput("startAck2_borrow", borrowout, expBorrow);
    ackResult("startAck2");

    // Reset after two RUN cycles aborts the operation.
    @(negedge clk);
    start = 1'b1; x = W'(9); y = W'(3); borrowin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", ready, 1);
    checkOutput("abort_valid", valid, 0);
    checkOutput("abort_out", out, 0);
    checkOutput("abort_borrow", borrowout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 2 * W + 2; i++) begin
      @(negedge clk);
      if (valid) sawValid = 1'b1;
    end
    checkOutput("abort_noValid", sawValid, 0);
    applyStimulus("afterAbort", 9, 3, 0, 1'b0);
    ackResult("afterAbort");

    // Randomized requests against the reference model.
    for (int n = 0; n < 24; n++) begin
      rx = int'($urandom_range((1 << W) - 1, 0));
      ry = int'($urandom_range((1 << W) - 1, 0));
      rb = int'($urandom_range(1, 0));
      applyStimulus("rand", rx, ry, rb, n[0]);
      ackResult("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
